// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared FSM states, strobe level and bus width for the RTC bus sequencers
package rtc_bus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_HOLD, S_DATA, S_DONE} rtc_state_e;
  localparam logic STROBE_IDLE = 1'b1;
  localparam int BUS_W = 8;
  function automatic logic bcd_invalid(input logic [BUS_W-1:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction
endpackage

// File: rtl/rtc_read_ctrl_if.sv
// rtc_read_ctrl_if: request side (start, addr_in, bus_in) and RTC bus side (strobes, bus_oe, addr_out, data_out, busy, done, bcd_err) of the read sequencer
interface rtc_read_ctrl_if import rtc_bus_pkg::*;;
  logic             start;
  logic [BUS_W-1:0] addr_in;
  logic [BUS_W-1:0] bus_in;
  logic             AD_R;
  logic             CS_R;
  logic             RD_R;
  logic             WR_R;
  logic             bus_oe;
  logic [BUS_W-1:0] addr_out;
  logic [BUS_W-1:0] data_out;
  logic             busy;
  logic             done;
  logic             bcd_err;
  modport master (input start, addr_in, bus_in,
                  output AD_R, CS_R, RD_R, WR_R, bus_oe, addr_out, data_out, busy, done, bcd_err);
  modport slave  (output start, addr_in, bus_in,
                  input AD_R, CS_R, RD_R, WR_R, bus_oe, addr_out, data_out, busy, done, bcd_err);
endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter (T_PHASE-1 .. 0) with zero flag
// Ports: clk, reset_n (async active-low), load (reload to T_PHASE-1), zero (count is 0)
module rtc_phase_timer #(parameter int T_PHASE = 10) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic zero
);
  localparam int W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(T_PHASE - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? LOAD_VAL : (zero ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/rtc_read_ctrl.sv
// rtc_read_ctrl: RTC multiplexed-bus read sequencer (ADDR, ADDR_HOLD, DATA, DONE)
// Ports: clk, reset_n (async active-low), bus (rtc_read_ctrl_if.master: start/addr_in/bus_in in,
// AD_R/CS_R/RD_R/WR_R/bus_oe/addr_out/data_out/busy/done/bcd_err out)
// Optional: define RTC_READ_BCD_CHECK_EN to flag captured bytes with a nibble above 9 on bcd_err.
module rtc_read_ctrl import rtc_bus_pkg::*; #(parameter int T_PHASE = 10) (
  input  logic clk,
  input  logic reset_n,
  rtc_read_ctrl_if.master bus
);
  rtc_state_e state_q, state_d;
  logic ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [BUS_W-1:0] addr_q, addr_d, data_q, data_d;
  logic zero, capture;
  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk(clk), .reset_n(reset_n), .load(state_d != state_q), .zero(zero)
  );
  assign capture = (state_q == S_DATA) && zero;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = capture ? bus.bus_in : data_q;
    unique case (state_q)
      S_IDLE:      if (bus.start) begin
                     state_d = S_ADDR;
                     addr_d  = bus.addr_in;
                   end
      S_ADDR:      if (zero) state_d = S_ADDR_HOLD;
      S_ADDR_HOLD: if (zero) state_d = S_DATA;
      S_DATA:      if (zero) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state and registered, so they align with state_q glitch-free
    ad_d   = (state_d == S_ADDR) ? ~STROBE_IDLE : STROBE_IDLE;
    cs_d   = (state_d == S_ADDR || state_d == S_DATA) ? ~STROBE_IDLE : STROBE_IDLE;
    rd_d   = (state_d == S_DATA) ? ~STROBE_IDLE : STROBE_IDLE;
    wr_d   = ad_d;
    oe_d   = (state_d == S_ADDR || state_d == S_ADDR_HOLD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      {ad_q, cs_q, rd_q, wr_q} <= {4{STROBE_IDLE}};
      {oe_q, busy_q, done_q} <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      {ad_q, cs_q, rd_q, wr_q} <= {ad_d, cs_d, rd_d, wr_d};
      {oe_q, busy_q, done_q} <= {oe_d, busy_d, done_d};
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign bus.AD_R     = ad_q;
  assign bus.CS_R     = cs_q;
  assign bus.RD_R     = rd_q;
  assign bus.WR_R     = wr_q;
  assign bus.bus_oe   = oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;
`ifdef RTC_READ_BCD_CHECK_EN
  logic bcd_q, bcd_d;
  always_comb bcd_d = capture ? bcd_invalid(bus.bus_in) : bcd_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bcd_q <= 1'b0;
    else bcd_q <= bcd_d;
  assign bus.bcd_err = bcd_q;
`else
  assign bus.bcd_err = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_read_ctrl.sv
// tb_rtc_read_ctrl: randomized self-checking bench for rtc_read_ctrl at T_PHASE=10 and T_PHASE=1
module tb_rtc_read_ctrl;
  localparam int T = 10;
`ifdef RTC_READ_BCD_CHECK_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  rtc_read_ctrl_if a_if ();
  rtc_read_ctrl_if b_if ();
  rtc_read_ctrl #(.T_PHASE(T)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if.master));
  rtc_read_ctrl #(.T_PHASE(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if.master));
  int checks = 0;
  int passed = 0;
  logic [7:0] pa = '0, pd = '0, qa = '0, qd = '0;
  logic pb = 1'b0, qb = 1'b0;

  // Expected {AD,CS,RD,WR,bus_oe,busy,done} in cycle k after start was sampled at edge 0
  function automatic logic [6:0] exp_ctl(input int t, input int k);
    bit in_a, in_h, in_d;
    in_a = (k >= 1) && (k <= t);
    in_h = (k > t) && (k <= 2 * t);
    in_d = (k > 2 * t) && (k <= 3 * t);
    return {!in_a, !(in_a || in_d), !in_d, !in_a, in_a || in_h, (k >= 1) && (k <= 3 * t + 1), k == 3 * t + 1};
  endfunction

  function automatic logic bcd_model(input logic [7:0] d);
    return BCD_EN && ((int'(d) / 16 > 9) || (int'(d) % 16 > 9));
  endfunction

  task automatic idle_a();
    @(posedge clk); #1;
    a_if.start = 1'b0;
    checks++;
    if ({a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done} !== 7'b1111000)
      $display("FAIL idle_a ctl got %b exp 1111000", {a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done});
    else passed++;
  endtask

  task automatic run_a(input logic [7:0] a, input logic [7:0] d, input bit junk, input int abort_k);
    logic [7:0] cap = '0;
    logic [6:0] ctl;
    @(posedge clk); #1;
    checks++;
    if ({a_if.busy, a_if.done, a_if.RD_R} !== 3'b001)
      $display("FAIL pre_start busy/done/rd got %b exp 001", {a_if.busy, a_if.done, a_if.RD_R});
    else passed++;
    a_if.start = 1'b1;
    a_if.addr_in = a;
    a_if.bus_in = 8'($urandom);
    for (int k = 1; k <= 3 * T + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) pa = a;
      if (k == 3 * T + 1) begin
        pd = cap;
        pb = bcd_model(cap);
      end
      ctl = {a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done};
      checks++;
      if (ctl !== exp_ctl(T, k)) $display("FAIL ctl k=%0d got %b exp %b", k, ctl, exp_ctl(T, k));
      else passed++;
      checks++;
      if (a_if.addr_out !== pa) $display("FAIL addr_out k=%0d got %h exp %h", k, a_if.addr_out, pa);
      else passed++;
      checks++;
      if (a_if.data_out !== pd) $display("FAIL data_out k=%0d got %h exp %h", k, a_if.data_out, pd);
      else passed++;
      checks++;
      if (a_if.bcd_err !== pb) $display("FAIL bcd_err k=%0d got %b exp %b", k, a_if.bcd_err, pb);
      else passed++;
      if (k == abort_k) begin
        #2 reset_n = 1'b0;
        #1;
        {pa, pd, pb, qa, qd, qb} = '0;
        a_if.start = 1'b0;
        checks++;
        if ({a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done,
             a_if.addr_out, a_if.data_out, a_if.bcd_err} !== {7'b1111000, 17'h0})
          $display("FAIL async_reset ctl=%b addr=%h data=%h bcd=%b exp 1111000/00/00/0",
                   {a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done},
                   a_if.addr_out, a_if.data_out, a_if.bcd_err);
        else passed++;
        #2 reset_n = 1'b1;
        return;
      end
      a_if.start = junk ? (k == 2 * T + 5 || k == 3 * T + 1 || $urandom_range(0, 3) == 0) : 1'b0;
      a_if.addr_in = 8'($urandom);
      a_if.bus_in = (k == 3 * T) ? d : 8'($urandom);
      if (k == 3 * T) cap = d;
    end
  endtask

  task automatic run_b(input logic [7:0] a, input logic [7:0] d);
    logic [6:0] ctl;
    @(posedge clk); #1;
    b_if.start = 1'b1;
    b_if.addr_in = a;
    b_if.bus_in = 8'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) qa = a;
      if (k == 4) begin
        qd = d;
        qb = bcd_model(d);
      end
      ctl = {b_if.AD_R, b_if.CS_R, b_if.RD_R, b_if.WR_R, b_if.bus_oe, b_if.busy, b_if.done};
      checks++;
      if (ctl !== exp_ctl(1, k) || b_if.addr_out !== qa || b_if.data_out !== qd || b_if.bcd_err !== qb)
        $display("FAIL t1 k=%0d ctl=%b addr=%h data=%h bcd=%b exp %b/%h/%h/%b",
                 k, ctl, b_if.addr_out, b_if.data_out, b_if.bcd_err, exp_ctl(1, k), qa, qd, qb);
      else passed++;
      b_if.start = 1'b0;
      b_if.addr_in = 8'($urandom);
      b_if.bus_in = (k == 3) ? d : 8'($urandom);
    end
    @(posedge clk); #1;
    checks++;
    if ({b_if.busy, b_if.done} !== 2'b00) $display("FAIL t1_idle busy/done got %b exp 00", {b_if.busy, b_if.done});
    else passed++;
  endtask

  task automatic test_reset();
    #13;
    checks++;
    if ({a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done,
         a_if.addr_out, a_if.data_out, a_if.bcd_err} !== {7'b1111000, 17'h0})
      $display("FAIL reset_a got %b exp all idle", {a_if.AD_R, a_if.CS_R, a_if.RD_R, a_if.WR_R, a_if.bus_oe, a_if.busy, a_if.done});
    else passed++;
    checks++;
    if ({b_if.AD_R, b_if.CS_R, b_if.RD_R, b_if.WR_R, b_if.bus_oe, b_if.busy, b_if.done,
         b_if.addr_out, b_if.data_out, b_if.bcd_err} !== {7'b1111000, 17'h0})
      $display("FAIL reset_b got %b exp all idle", {b_if.AD_R, b_if.CS_R, b_if.RD_R, b_if.WR_R, b_if.bus_oe, b_if.busy, b_if.done});
    else passed++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_basic_read();
    run_a(8'h21, 8'h45, 1'b0, 0);
    idle_a();
  endtask

  task automatic test_ignored_start();
    run_a(8'($urandom), 8'($urandom), 1'b1, 0);
    run_a(8'($urandom), 8'($urandom), 1'b1, 0);
    idle_a();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_a(8'($urandom), 8'($urandom), 1'b0, 0);
    idle_a();
  endtask

  task automatic test_reset_mid_data();
    run_a(8'($urandom), 8'($urandom), 1'b0, 2 * T + 4);
    run_a(8'($urandom), 8'($urandom), 1'b0, 0);
    idle_a();
  endtask

  task automatic test_tphase1();
    run_b(8'h21, 8'h45);
    for (int i = 0; i < 3; i++) run_b(8'($urandom), 8'($urandom));
  endtask

  task automatic test_bcd();
    run_a(8'h10, 8'h3A, 1'b0, 0);
    run_a(8'h11, 8'h59, 1'b0, 0);
    run_b(8'h12, 8'hA5);
    run_b(8'h13, 8'h99);
    idle_a();
  endtask

  initial begin
    {a_if.start, a_if.addr_in, a_if.bus_in} = '0;
    {b_if.start, b_if.addr_in, b_if.bus_in} = '0;
    test_reset();
    test_basic_read();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_data();
    test_tphase1();
    test_bcd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
